iobuf_slot_ctrl: RTL and testbench
==================================

IOBUF_SLOT_CTRL -- requirements
Module: iobuf_slot_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: slot counter width; every T_* value SHALL fit in CNT_W bits.
REQ-002 Parameter T_SLOT, default 3500: bit-slot length, in clock cycles.
REQ-003 Parameter T_LOW0, default 3000: low time for a write-0, in cycles.
REQ-004 Parameter T_LOW1, default 300: low time for a write-1 or a read, in cycles.
REQ-005 Parameter T_SAMPLE, default 600: read sample point, counted from slot start.
REQ-006 Parameter T_REC, default 250: recovery time after every pad command, in cycles.
REQ-007 Parameter T_RSTL, default 24000: reset low time, and also the reset release window length.
REQ-008 Parameter T_PRES, default 3500: presence sample point, counted from reset release.
REQ-009 Parameter legality: 0<T_LOW1<T_SAMPLE<T_SLOT; T_LOW1<T_LOW0<T_SLOT; 0<T_PRES<T_RSTL; T_REC>=1.
REQ-010 Port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-011 Port reset_n, input, 1: asynchronous active-low reset.
REQ-012 Port cmd_valid, input, 1: command request.
REQ-013 Port cmd_ready, output, 1: controller can accept a command.
REQ-014 Port cmd_op, input, 2: 00 WRITE, 01 READ, 10 BUSRESET, 11 reserved.
REQ-015 Port cmd_bit, input, 1: bit value for WRITE.
REQ-016 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-017 Port rsp_data, output, 1: read bit, presence flag, or 0.
REQ-018 Port rsp_err, output, 1: the command was the reserved op.
REQ-019 Port pad_oe, output, 1: drives the iobuf oe; 1 pulls the pad low.
REQ-020 Port pad_datain, output, 1: drives the iobuf datain; SHALL be constant 0 (open-drain use).
REQ-021 Port pad_dataout, input, 1: from the iobuf dataout; asynchronous to clock.

Function
REQ-022 pad_dataout SHALL pass through a 2-flop synchronizer; all samples SHALL use the synchronizer output.
REQ-023 FSM states: IDLE, LOW, RELEASE, RECOVER, RESP.
REQ-024 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge with cmd_valid&&cmd_ready (accept cycle k).
REQ-025 cmd_op and cmd_bit SHALL be latched at accept and ignored for the rest of the command.
REQ-026 WRITE: pad_oe=1 in cycles k+1..k+TL, with TL=T_LOW1 if the bit is 1 and T_LOW0 if 0; pad_oe=0 in k+TL+1..k+T_SLOT.
REQ-027 READ: pad_oe=1 in k+1..k+T_LOW1, then 0 through k+T_SLOT; rsp_data = synchronizer output captured at the cycle-(k+T_SAMPLE) edge.
REQ-028 BUSRESET: pad_oe=1 in k+1..k+T_RSTL, then 0 in k+T_RSTL+1..k+2*T_RSTL; rsp_data = inverted synchronizer output captured at the cycle-(k+T_RSTL+T_PRES) edge (1 = presence).
REQ-029 RECOVER: after the slot or window ends (at cycle E), pad_oe=0 for T_REC cycles (E+1..E+T_REC).
REQ-030 RESP: rsp_valid=1 for exactly one cycle at E+T_REC+1; cmd_ready=1 in that same cycle (FSM is back in IDLE); rsp_data=0 for WRITE.
REQ-031 Reserved op: no pad activity; rsp_valid=1 and rsp_err=1 at k+1; rsp_data=0.
REQ-032 rsp_err SHALL be 0 for all legal ops; rsp_data and rsp_err SHALL be held until the next rsp_valid.
REQ-033 rsp_valid has no backpressure; a back-to-back command MAY be accepted in the rsp_valid cycle.
REQ-034 The counter SHALL never wrap within a command; it clears on every state transition.
REQ-035 pad_oe SHALL be driven from a flop (glitch-free).

Reset
REQ-036 While reset_n=0: pad_oe=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, FSM=IDLE, counter=0, synchronizer flops=1.
REQ-037 Reset SHALL assert asynchronously; pad_oe SHALL release immediately, even mid-command; the in-flight command is dropped with no rsp_valid.
REQ-038 cmd_ready SHALL rise on the first clock edge after reset_n deasserts.

Verification (T_SLOT=20, T_LOW0=15, T_LOW1=3, T_SAMPLE=6, T_REC=2, T_RSTL=40, T_PRES=10)
REQ-039 WRITE bit=1 accepted at cycle 0 -> pad_oe=1 in cycles 1-3, 0 in 4-22; rsp_valid at 23 with rsp_data=0.
REQ-040 WRITE bit=0 accepted at cycle 0 -> pad_oe=1 in cycles 1-15; rsp_valid at 23.
REQ-041 READ with the pad model holding 1, then a READ holding 0 -> rsp_data=1, then rsp_data=0; pad_oe=1 in cycles 1-3 of each slot.
REQ-042 BUSRESET with the pad model pulling low over cycles 45-55 -> pad_oe=1 in cycles 1-40; rsp_valid at 83 with rsp_data=1; with no pull-low -> rsp_data=0.
REQ-043 reset_n low at cycle 8 of a WRITE-0 -> pad_oe=0 immediately; no rsp_valid; cmd_ready=1 on the first edge after release.
REQ-044 cmd_op=11 accepted at cycle 0 -> rsp_valid=1 and rsp_err=1 at cycle 1; pad_oe stays 0.

Source files
------------

// File: rtl/iobuf_slot_ctrl.sv
// Bit-slot controller for an open-drain single-wire bus driven through an iobuf.
// Sequences WRITE/READ slots and BUSRESET windows, samples the pad, and reports one response per command.
module iobuf_slot_ctrl #(
  parameter int CNT_W    = 16,
  parameter int T_SLOT   = 3500,
  parameter int T_LOW0   = 3000,
  parameter int T_LOW1   = 300,
  parameter int T_SAMPLE = 600,
  parameter int T_REC    = 250,
  parameter int T_RSTL   = 24000,
  parameter int T_PRES   = 3500
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic       pad_oe,
  output logic       pad_datain,
  input  logic       pad_dataout
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_BRST  = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  // Terminal counts: the counter restarts at 0 on entry to each state.
  localparam logic [CNT_W-1:0] LOW0_END  = CNT_W'(T_LOW0 - 1);
  localparam logic [CNT_W-1:0] LOW1_END  = CNT_W'(T_LOW1 - 1);
  localparam logic [CNT_W-1:0] RSTL_END  = CNT_W'(T_RSTL - 1);
  localparam logic [CNT_W-1:0] REL0_END  = CNT_W'(T_SLOT - T_LOW0 - 1);
  localparam logic [CNT_W-1:0] REL1_END  = CNT_W'(T_SLOT - T_LOW1 - 1);
  localparam logic [CNT_W-1:0] REC_END   = CNT_W'(T_REC - 1);
  localparam logic [CNT_W-1:0] SAMP_AT   = CNT_W'(T_SAMPLE - T_LOW1 - 1);
  localparam logic [CNT_W-1:0] PRES_AT   = CNT_W'(T_PRES - 1);

  typedef enum logic [2:0] {IDLE, LOW, RELEASE, RECOVER, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             bit_q;
  logic             samp;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] low_end;
  logic [CNT_W-1:0] rel_end;

  assign pad_datain = 1'b0;

  // Pad idles high on an open-drain bus, so the synchronizer resets to 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], pad_dataout};
  end

  always_comb begin
    low_end = LOW1_END;
    rel_end = REL1_END;
    if (op_q == OP_BRST) begin
      low_end = RSTL_END;
      rel_end = RSTL_END;
    end else if (op_q == OP_WRITE && !bit_q) begin
      low_end = LOW0_END;
      rel_end = REL0_END;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_WRITE;
      bit_q     <= 1'b0;
      samp      <= 1'b0;
      pad_oe    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            bit_q     <= cmd_bit;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_RSV) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 1'b0;
              state     <= RESP;
            end else begin
              pad_oe <= 1'b1;
              state  <= LOW;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        LOW: begin
          if (cnt == low_end) begin
            pad_oe <= 1'b0;
            cnt    <= '0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (op_q == OP_READ && cnt == SAMP_AT) samp <= sync_q[1];
          if (op_q == OP_BRST && cnt == PRES_AT) samp <= ~sync_q[1];
          if (cnt == rel_end) begin
            cnt   <= '0;
            state <= RECOVER;
          end
        end
        RECOVER: begin
          if (cnt == REC_END) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= (op_q == OP_WRITE) ? 1'b0 : samp;
            cmd_ready <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: begin
          pad_oe <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iobuf_slot_ctrl.sv
// Directed vector bench for iobuf_slot_ctrl with a small open-drain pad model.
module tb_iobuf_slot_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_bit;
  logic       rsp_valid;
  logic       rsp_data;
  logic       rsp_err;
  logic       pad_oe;
  logic       pad_datain;
  logic       pad_dataout;
  logic       pull;

  int passed = 0;
  int total  = 0;
  int rv_count = 0;

  always #5 clock = ~clock;

  // Open-drain bus: low if the controller or a device pulls it.
  assign pad_dataout = ~(pad_oe | pull);

  always @(posedge clock) if (rsp_valid) rv_count <= rv_count + 1;

  iobuf_slot_ctrl #(
    .CNT_W(16), .T_SLOT(20), .T_LOW0(15), .T_LOW1(3), .T_SAMPLE(6),
    .T_REC(2), .T_RSTL(40), .T_PRES(10)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_bit(cmd_bit),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pad_oe(pad_oe), .pad_datain(pad_datain), .pad_dataout(pad_dataout)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
  endtask

  typedef struct {
    logic [1:0] op;
    logic       b;
    int         ps, pe;   // pull-low window, in cycles after accept
    int         oe_hi;    // last cycle with pad_oe=1
    int         rsp;      // rsp_valid cycle
    int         data;
    int         err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, oe_bad, rsp_cyc, nv, g_data, g_err, g_rdy, hold;

    vecs[0] = '{2'b00, 1'b1, 1000, 1000,  3, 23, 0, 0};  // WRITE 1
    vecs[1] = '{2'b00, 1'b0, 1000, 1000, 15, 23, 0, 0};  // WRITE 0
    vecs[2] = '{2'b01, 1'b0, 1000, 1000,  3, 23, 1, 0};  // READ, bus high
    vecs[3] = '{2'b01, 1'b0,    0,   30,  3, 23, 0, 0};  // READ, device pulls low
    vecs[4] = '{2'b10, 1'b0,   45,   55, 40, 83, 1, 0};  // BUSRESET with presence
    vecs[5] = '{2'b10, 1'b0, 1000, 1000, 40, 83, 0, 0};  // BUSRESET, nobody there
    vecs[6] = '{2'b11, 1'b0, 1000, 1000,  0,  1, 0, 1};  // reserved op
    vecs[7] = '{2'b00, 1'b1, 1000, 1000,  3, 23, 0, 0};  // err clears after reserved

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_bit = 1'b0; pull = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("pad_datain", pad_datain, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("ready_first_edge", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      n = 0;
      @(negedge clock);
      while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
      chk($sformatf("v%0d_ready_wait", i), cmd_ready, 1);
      pull = (vecs[i].ps <= 1 && vecs[i].pe >= 1);
      cmd_op = vecs[i].op; cmd_bit = vecs[i].b; cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_bit = 1'b0;
      oe_bad = 0; rsp_cyc = -1; nv = 0; g_data = 0; g_err = 0; g_rdy = 0; hold = -1;
      for (int c = 1; c <= vecs[i].rsp + 1; c++) begin
        pull = (c >= vecs[i].ps && c <= vecs[i].pe);
        @(negedge clock);
        if (c <= vecs[i].rsp && pad_oe !== (c <= vecs[i].oe_hi)) oe_bad++;
        if (rsp_valid) begin
          nv++;
          if (rsp_cyc < 0) begin
            rsp_cyc = c; g_data = rsp_data; g_err = rsp_err; g_rdy = cmd_ready;
          end
        end
        if (c == vecs[i].rsp + 1) hold = rsp_data;
        @(posedge clock); #1;
      end
      pull = 1'b0;
      chk($sformatf("v%0d_oe_pattern_errs", i), oe_bad, 0);
      chk($sformatf("v%0d_rsp_cycle", i), rsp_cyc, vecs[i].rsp);
      chk($sformatf("v%0d_rsp_count", i), nv, 1);
      chk($sformatf("v%0d_rsp_data", i), g_data, vecs[i].data);
      chk($sformatf("v%0d_rsp_err", i), g_err, vecs[i].err);
      chk($sformatf("v%0d_data_hold", i), hold, vecs[i].data);
      if (vecs[i].op != 2'b11) chk($sformatf("v%0d_ready_at_rsp", i), g_rdy, 1);
    end

    // Reset in the middle of a WRITE-0 low phase.
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
    cmd_op = 2'b00; cmd_bit = 1'b0; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("midcmd_oe_before_reset", pad_oe, 1);
    n = rv_count;
    reset_n = 1'b0;
    #1;
    chk("midcmd_oe_async_release", pad_oe, 0);
    chk("midcmd_ready_in_reset", cmd_ready, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("midcmd_ready_before_edge", cmd_ready, 0);
    @(posedge clock); #1;
    chk("midcmd_ready_first_edge", cmd_ready, 1);
    repeat (30) @(posedge clock);
    #1;
    chk("midcmd_no_rsp", rv_count - n, 0);
    chk("midcmd_oe_idle", pad_oe, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
